// File: rtl/mbc1_pkg.sv
// Shared definitions for the MBC1 cartridge bus front end.
//   cmd_sel_e  : register targeted by a cartridge write (A14..A13)
//   cmd_t      : queued register-write command {sel, data}
//   fe_state_e : nWR pulse qualification states
package mbc1_pkg;

  localparam int unsigned MIN_LOW_DEF  = 3;
  localparam int unsigned GLITCH_W_DEF = 8;
  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned DATA_W       = 5;
  localparam int unsigned SEL_W        = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_RAMEN = 2'd0,
    SEL_ROMB  = 2'd1,
    SEL_HIB   = 2'd2,
    SEL_MODE  = 2'd3
  } cmd_sel_e;

  typedef struct packed {
    cmd_sel_e          sel;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOW  = 1'b1
  } fe_state_e;

endpackage

// File: rtl/mbc1_sync2.sv
// Two-flop synchronizer for an asynchronous input group.
//   clk, nres : clock and async active-low reset (flops load RST_VAL)
//   d         : asynchronous input
//   q         : synchronized output
module mbc1_sync2 #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nres,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/mbc1_bus_frontend.sv
// MBC1 cartridge bus front end: synchronizes the bus, qualifies nWR pulses
// and queues register-write commands in a 2-entry FIFO.
//   clk, nres          : clock, async active-low reset
//   bus_nwr/nrd/a/d    : asynchronous cartridge bus inputs
//   cmd_valid/ready    : command handshake towards the MBC register core
//   cmd_sel, cmd_data  : head command payload
//   ovf, ovf_clr       : sticky drop-on-full flag and its clear
//   glitch_cnt         : saturating count of rejected write pulses
module mbc1_bus_frontend
  import mbc1_pkg::*;
#(
  parameter int unsigned MIN_LOW  = MIN_LOW_DEF,
  parameter int unsigned GLITCH_W = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                nres,
  input  logic                bus_nwr,
  input  logic                bus_nrd,
  input  logic [ADDR_W-1:0]   bus_a,
  input  logic [DATA_W-1:0]   bus_d,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [SEL_W-1:0]    cmd_sel,
  output logic [DATA_W-1:0]   cmd_data,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned LOW_CNT_W = $clog2(MIN_LOW + 1);

  logic              nwr_s, nrd_s;
  logic [ADDR_W-1:0] a_s;
  logic [DATA_W-1:0] d_s;

  mbc1_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_nwr (
    .clk(clk), .nres(nres), .d(bus_nwr), .q(nwr_s));
  mbc1_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_nrd (
    .clk(clk), .nres(nres), .d(bus_nrd), .q(nrd_s));
  mbc1_sync2 #(.WIDTH(ADDR_W), .RST_VAL('0)) u_sync_a (
    .clk(clk), .nres(nres), .d(bus_a), .q(a_s));
  mbc1_sync2 #(.WIDTH(DATA_W), .RST_VAL('0)) u_sync_d (
    .clk(clk), .nres(nres), .d(bus_d), .q(d_s));

  fe_state_e          state_q, state_d;
  logic [LOW_CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic               conflict_q, conflict_d;
  logic [ADDR_W-1:0]  shadow_a_q, shadow_a_d;
  logic [DATA_W-1:0]  shadow_d_q, shadow_d_d;
  logic               wr_eval;

  // Pulse qualification. low_cnt counts synchronized low cycles, so the entry
  // cycle (first nwr_s=0) restarts it at one rather than carrying old counts.
  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    conflict_d = conflict_q;
    shadow_a_d = shadow_a_q;
    shadow_d_d = shadow_d_q;
    wr_eval    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!nwr_s) begin
          state_d    = ST_LOW;
          low_cnt_d  = LOW_CNT_W'(1);
          conflict_d = !nrd_s;
          shadow_a_d = a_s;
          shadow_d_d = d_s;
        end
      end
      ST_LOW: begin
        if (!nwr_s) begin
          if (low_cnt_q < LOW_CNT_W'(MIN_LOW)) low_cnt_d = low_cnt_q + LOW_CNT_W'(1);
          conflict_d = conflict_q | !nrd_s;
          shadow_a_d = a_s;
          shadow_d_d = d_s;
        end else begin
          state_d = ST_IDLE;
          wr_eval = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write verdict on the rising edge of nwr_s; A15=1 targets RAM/IO and is ignored.
  logic wr_good, push_req, glitch_inc;
  assign wr_good    = (low_cnt_q >= LOW_CNT_W'(MIN_LOW)) && !conflict_q;
  assign push_req   = wr_eval && !shadow_a_q[ADDR_W-1] && wr_good;
  assign glitch_inc = wr_eval && !shadow_a_q[ADDR_W-1] && !wr_good;

  // 2-entry FIFO: head lives directly in the output registers, tail behind it.
  cmd_t        head_q, head_d, tail_q, tail_d, new_cmd;
  logic [1:0]  count_q, count_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        pop, push, drop;
  logic        ovf_q, ovf_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  assign new_cmd = '{sel: cmd_sel_e'(shadow_a_q[SEL_W-1:0]), data: shadow_d_q};
  assign pop     = cmd_valid_q && cmd_ready;
  assign push    = push_req && ((count_q != 2'd2) || pop);
  assign drop    = push_req && (count_q == 2'd2) && !pop;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    glitch_d = glitch_q;
    if (pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      else if (push)       head_d = new_cmd;
    end else if (push && (count_q == 2'd0)) begin
      head_d = new_cmd;
    end
    if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop))) tail_d = new_cmd;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Overflow wins over a same-cycle clear.
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
    if (glitch_inc && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_W'(1);
  end

  assign cmd_valid_d = (count_d != 2'd0);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q     <= ST_IDLE;
      low_cnt_q   <= '0;
      conflict_q  <= 1'b0;
      shadow_a_q  <= '0;
      shadow_d_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      cmd_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      glitch_q    <= '0;
    end else begin
      state_q     <= state_d;
      low_cnt_q   <= low_cnt_d;
      conflict_q  <= conflict_d;
      shadow_a_q  <= shadow_a_d;
      shadow_d_q  <= shadow_d_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      ovf_q       <= ovf_d;
      glitch_q    <= glitch_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_sel    = head_q.sel;
  assign cmd_data   = head_q.data;
  assign ovf        = ovf_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_mbc1_bus_frontend.sv
// Self-checking bench for mbc1_bus_frontend: directed scenarios plus random
// bus writes scored against a transaction-level reference model.
module tb_mbc1_bus_frontend;

  localparam int unsigned MIN_LOW  = 3;
  localparam int unsigned GLITCH_W = 8;
  localparam int unsigned GAP      = 6;

  logic                clk = 1'b0;
  logic                nres = 1'b0;
  logic                bus_nwr = 1'b1;
  logic                bus_nrd = 1'b1;
  logic [2:0]          bus_a = '0;
  logic [4:0]          bus_d = '0;
  logic                cmd_valid;
  logic                cmd_ready = 1'b0;
  logic [1:0]          cmd_sel;
  logic [4:0]          cmd_data;
  logic                ovf;
  logic                ovf_clr = 1'b0;
  logic [GLITCH_W-1:0] glitch_cnt;

  mbc1_bus_frontend #(.MIN_LOW(MIN_LOW), .GLITCH_W(GLITCH_W)) dut (
    .clk(clk), .nres(nres), .bus_nwr(bus_nwr), .bus_nrd(bus_nrd),
    .bus_a(bus_a), .bus_d(bus_d), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data), .ovf(ovf), .ovf_clr(ovf_clr),
    .glitch_cnt(glitch_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of commands still owed to the core, sticky flag, counter.
  logic [6:0] exp_q[$];
  logic       m_ovf = 1'b0;
  int         m_glitch = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every handshake must deliver the oldest owed command.
  always @(negedge clk) begin
    if (nres && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("pop_cmd", 32'({cmd_sel, cmd_data}), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic end_checks(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'({cmd_sel, cmd_data}), 32'(exp_q[0]));
    check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, "_glitch"}, 32'(glitch_cnt), 32'(m_glitch));
  endtask

  // One cartridge write: nWR low for len cycles, nRD low at cycle rd_at (-1 none).
  // rdy_mode: 0 ready low, 1 ready high, 2 ready high only on the push edge.
  // clr_mode: 0 none, 1 clear before the pulse, 2 clear held through the push edge.
  task automatic do_write(input string tag, input logic [2:0] a, input logic [4:0] d,
                          input int len, input int rd_at, input int rdy_mode, input int clr_mode);
    bit conflict;
    bit good;
    bit drop;
    conflict = (rd_at >= 0) && (rd_at < len);
    good     = (len >= int'(MIN_LOW)) && !conflict;
    drop     = 1'b0;
    if (!a[2]) begin
      if (good) begin
        if (rdy_mode == 0 && exp_q.size() >= 2) drop = 1'b1;
        else exp_q.push_back({a[1:0], d});
      end else if (m_glitch < 255) begin
        m_glitch++;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_mode != 0) m_ovf = 1'b0;

    @(posedge clk); #1;
    cmd_ready = (rdy_mode == 1);
    ovf_clr   = (clr_mode == 1);
    bus_a     = a;
    bus_d     = d;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    bus_nwr = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus_nrd = (i == rd_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    bus_nwr = 1'b1;
    bus_nrd = 1'b1;
    bus_a   = 3'($urandom);
    bus_d   = 5'($urandom);
    if (clr_mode == 2) ovf_clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (rdy_mode == 2) cmd_ready = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    if (rdy_mode == 2) cmd_ready = 1'b0;
    repeat (GAP - 3) @(posedge clk);
    #1;
    end_checks(tag);
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    end_checks(tag);
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_sel", 32'(cmd_sel), 32'd0);
    check("rst_data", 32'(cmd_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_glitch", 32'(glitch_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 nres = 1'b1;

    // Basic ROMB write, then glitch and RAM-region cases.
    do_write("romb", 3'b001, 5'h05, 6, -1, 0, 0);
    check("romb_sel", 32'(cmd_sel), 32'd1);
    check("romb_data", 32'(cmd_data), 32'h05);
    drain("romb_drain");
    do_write("short2", 3'b010, 5'h0A, 2, -1, 1, 0);
    check("short2_glitch", 32'(glitch_cnt), 32'd1);
    do_write("ramio", 3'b101, 5'h11, 6, -1, 1, 0);
    do_write("minlow", 3'b011, 5'h13, int'(MIN_LOW), -1, 0, 0);
    drain("minlow_drain");

    // Overflow: three writes into a stalled 2-entry FIFO.
    do_write("ovf1", 3'b001, 5'd1, 4, -1, 0, 1);
    do_write("ovf2", 3'b001, 5'd2, 4, -1, 0, 0);
    do_write("ovf3", 3'b001, 5'd3, 4, -1, 0, 0);
    drain("ovf_drain");

    // Clear and overflow on the same edge; then a plain clear.
    do_write("prio1", 3'b000, 5'd9, 4, -1, 0, 0);
    do_write("prio2", 3'b010, 5'd10, 4, -1, 0, 0);
    do_write("prio3", 3'b011, 5'd11, 4, -1, 0, 2);
    do_write("clr", 3'b100, 5'd0, 4, -1, 0, 1);

    // Full FIFO with push and pop on the same edge.
    do_write("pp", 3'b001, 5'd7, 4, -1, 2, 0);
    drain("pp_drain");

    // nRD during the nWR window.
    do_write("conflict", 3'b010, 5'h1F, 6, 2, 1, 0);

    for (int n = 0; n < 200; n++) begin
      int len;
      int rd_at;
      len   = int'($urandom_range(1, 6));
      rd_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_write("rnd", 3'($urandom), 5'($urandom), len, rd_at,
               int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    drain("rnd_drain");

    for (int n = 0; n < 300; n++) do_write("sat", 3'b000, 5'($urandom), 1, -1, 0, 0);
    check("glitch_sat", 32'(glitch_cnt), 32'hFF);

    // Asynchronous reset with two commands queued.
    do_write("rq1", 3'b001, 5'd4, 5, -1, 0, 0);
    do_write("rq2", 3'b011, 5'd5, 5, -1, 0, 0);
    @(posedge clk); #2;
    nres = 1'b0;
    #1;
    check("ares_valid", 32'(cmd_valid), 32'd0);
    check("ares_ovf", 32'(ovf), 32'd0);
    check("ares_glitch", 32'(glitch_cnt), 32'd0);
    exp_q.delete();
    m_ovf    = 1'b0;
    m_glitch = 0;
    @(posedge clk); #1;
    nres      = 1'b1;
    cmd_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    end_checks("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbc1_bus_frontend.md
MBC1_BUS_FRONTEND -- requirements
Module: mbc1_bus_frontend

Interface
REQ-001 SHALL have parameter MIN_LOW, default 3: minimum synchronized nWR-low cycles for a valid write.
REQ-002 SHALL have parameter GLITCH_W, default 8: width of the glitch counter.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-004 SHALL have port nres, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port bus_nwr, input, 1 bit: cartridge nWR, asynchronous.
REQ-006 SHALL have port bus_nrd, input, 1 bit: cartridge nRD, asynchronous.
REQ-007 SHALL have port bus_a, input, 3 bits: cartridge A15..A13, asynchronous.
REQ-008 SHALL have port bus_d, input, 5 bits: cartridge D4..D0, asynchronous.
REQ-009 SHALL have port cmd_valid, output, 1 bit: FIFO head holds a register-write command.
REQ-010 SHALL have port cmd_ready, input, 1 bit: the MBC register core accepts the head.
REQ-011 SHALL have port cmd_sel, output, 2 bits: target register (A14..A13 of the write).
REQ-012 SHALL have port cmd_data, output, 5 bits: write data D4..D0.
REQ-013 SHALL have port ovf, output, 1 bit: sticky flag, a command was dropped on a full FIFO.
REQ-014 SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf.
REQ-015 SHALL have port glitch_cnt, output, GLITCH_W bits: saturating count of rejected write pulses.

Function
REQ-016 SHALL pass bus_nwr, bus_nrd, bus_a and bus_d through a 2-flop synchronizer; the synchronized versions are nwr_s, nrd_s, a_s and d_s, and all logic uses only these.
REQ-017 SHALL implement FSM IDLE/LOW: IDLE->LOW when nwr_s=0; LOW->IDLE when nwr_s=1.
REQ-018 SHALL, in LOW, increment low_cnt each cycle, saturating at MIN_LOW; low_cnt clears on entry to LOW.
REQ-019 SHALL, in LOW, register a_s and d_s into a shadow register on every cycle, so the last value sampled while nwr_s=0 is kept.
REQ-020 SHALL, in LOW, set a conflict bit if nrd_s=0 in any cycle.
REQ-021 SHALL evaluate the write on the LOW->IDLE cycle N: valid if low_cnt>=MIN_LOW, conflict=0 and shadow A15=0.
REQ-022 SHALL, for a valid write, push {shadow A14..A13, shadow D} into the FIFO so that cmd_valid is 1 at cycle N+1 if the FIFO was empty.
REQ-023 SHALL drop a valid write that finds the FIFO full with no pop in the same cycle, and set ovf.
REQ-024 SHALL ignore writes with shadow A15=1 (RAM/IO region): no push and no glitch count.
REQ-025 SHALL increment glitch_cnt for a low_cnt or conflict failure, saturating at all-ones.
REQ-026 SHALL use a 2-entry FIFO in first-in, first-out order; a pop occurs when cmd_valid and cmd_ready are both 1.
REQ-027 SHALL accept both a simultaneous push and pop when the FIFO is full; ovf is not set.
REQ-028 SHALL hold cmd_sel and cmd_data stable while cmd_valid=1 and cmd_ready=0.
REQ-029 SHALL give ovf_clr priority below a same-cycle overflow set: ovf stays 1.

Reset
REQ-030 SHALL, on nres=0, set immediately: synchronizer flops to nwr_s=1, nrd_s=1, a_s=0, d_s=0; FSM=IDLE; low_cnt=0; FIFO empty; cmd_valid=0; cmd_sel=0; cmd_data=0; ovf=0; glitch_cnt=0.
REQ-031 SHALL treat a bus_nwr low pulse already in progress at reset release as a new pulse; its shortened low time is judged by REQ-021.

Structure
REQ-032 SHALL place the cmd_sel encoding (RAMEN=0, ROMB=1, HIB=2, MODE=3), the command struct {sel, data} and the MIN_LOW default in the shared package mbc1_pkg.
REQ-033 SHALL implement the 2-flop synchronizer as sub-module mbc1_sync2, parameterized by width and reset value, and instantiate it once per bus signal group.

Verification
REQ-034 SHALL cover: bus_a=3'b001, bus_d=5'h05, nWR low for 6 cycles -> cmd_valid at rise+1, cmd_sel=1, cmd_data=5'h05, glitch_cnt=0.
REQ-035 SHALL cover: nWR low for 2 cycles, MIN_LOW=3 -> no cmd_valid, glitch_cnt=1; bus_a=3'b101 with nWR low for 6 cycles -> no cmd_valid, glitch_cnt unchanged.
REQ-036 SHALL cover: cmd_ready=0 and three valid writes with data 1, 2, 3 -> FIFO holds 1 then 2, ovf=1; cmd_ready=1 then pops 1, 2.
REQ-037 SHALL cover: FIFO full, cmd_ready=1 in the same cycle as a new push with data 7 -> ovf=0, output order preserved, 7 last.
REQ-038 SHALL cover: nRD low during an nWR-low window -> no push, glitch_cnt+1; 300 short pulses -> glitch_cnt=8'hFF.
REQ-039 SHALL cover: nres asserted with two entries queued -> cmd_valid=0 with no clock edge; after release, no spurious command appears.
